// File: rtl/s3g_pkg.sv
// Shared S3G protocol constants, FSM encodings and the CRC-8/Maxim byte helper.
package s3g_pkg;

    localparam logic [7:0] S3G_START_BYTE = 8'hD5;
    localparam logic [7:0] CRC8_POLY_REFL = 8'h8C;

    // Response codes returned by the command executor.
    localparam logic [7:0] RC_OK          = 8'h81;
    localparam logic [7:0] RC_UNSUPPORTED = 8'h85;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CRC     = 3'd4,
        ST_WAIT    = 3'd5
    } framer_state_t;

    // Where WAIT goes once the transceiver reports the byte as sent.
    typedef enum logic [1:0] {
        NX_LEN     = 2'd0,
        NX_PAYLOAD = 2'd1,
        NX_CRC     = 2'd2,
        NX_DONE    = 2'd3
    } framer_next_t;

    // CRC-8/Maxim (reflected, LSB first) folded over one data byte.
    function automatic logic [7:0] crc8_maxim_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC8_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/s3g_payload_buf.sv
// Byte RAM holding one response payload: one write port, one registered read port.
module s3g_payload_buf #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    // Storage array; the controller never writes past DEPTH-1.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end else begin
            mem_q[wr_addr] <= mem_q[wr_addr];
        end
    end

    // Registered read; addresses beyond the array return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 8'h00;
        end else if (32'(rd_addr) < DEPTH) begin
            rd_data_q <= mem_q[rd_addr];
        end else begin
            rd_data_q <= 8'h00;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/s3g_resp_framer.sv
// Frames a buffered S3G response as D5, len, payload, CRC-8/Maxim, paced by tx_done.
module s3g_resp_framer
    import s3g_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD = 32,
    parameter logic [7:0]  START_BYTE  = S3G_START_BYTE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pl_data,
    input  logic        pl_wr,
    input  logic        pl_commit,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_done,
    output logic [15:0] frames_sent
);

    localparam int unsigned AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [8:0]  MAX_LEN = 9'(MAX_PAYLOAD);

    if (MAX_PAYLOAD < 1 || MAX_PAYLOAD > 255) begin : g_bad_max_payload
        $error("s3g_resp_framer: MAX_PAYLOAD must be within 1..255");
    end

    framer_state_t state_q, state_d;
    framer_next_t  next_q, next_d;
    logic [7:0]    wptr_q, wptr_d;
    logic [7:0]    rptr_q, rptr_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    crc_q, crc_d;
    logic          busy_q, busy_d;
    logic          overflow_q, overflow_d;
    logic          dropped_q, dropped_d;   // a write was dropped since the last accepted commit
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_wr_q, tx_wr_d;
    logic [15:0]   frames_q, frames_d;
    logic          buf_we_s;
    logic [7:0]    buf_rd_s;

    // Read address follows the next read pointer so buf_rd_s equals buf[rptr_q] during WAIT.
    s3g_payload_buf #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (buf_we_s),
        .wr_addr (wptr_q[AW-1:0]),
        .wr_data (pl_data),
        .rd_addr (rptr_d[AW-1:0]),
        .rd_data (buf_rd_s)
    );

    // Next-state, buffer control and next output values; each byte strobe is set on entry to its state.
    always_comb begin
        state_d    = state_q;
        next_d     = next_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        len_d      = len_q;
        crc_d      = crc_q;
        busy_d     = busy_q;
        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        tx_data_d  = tx_data_q;
        tx_wr_d    = 1'b0;
        frames_d   = frames_q;
        buf_we_s   = 1'b0;

        if (pl_wr && (state_q != ST_IDLE)) begin
            overflow_d = 1'b1;
            dropped_d  = 1'b1;
        end else begin
            dropped_d  = dropped_d;
        end

        case (state_q)
            ST_IDLE: begin
                if (pl_wr) begin
                    if ({1'b0, wptr_q} < MAX_LEN) begin
                        buf_we_s = 1'b1;
                        wptr_d   = wptr_q + 8'd1;
                    end else begin
                        overflow_d = 1'b1;
                        dropped_d  = 1'b1;
                    end
                end else begin
                    buf_we_s = 1'b0;
                end
                if (pl_commit) begin
                    len_d      = wptr_d;
                    rptr_d     = 8'd0;
                    crc_d      = 8'h00;
                    busy_d     = 1'b1;
                    overflow_d = dropped_d;
                    dropped_d  = 1'b0;
                    tx_data_d  = START_BYTE;
                    tx_wr_d    = 1'b1;
                    state_d    = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                next_d  = NX_LEN;
                state_d = ST_WAIT;
            end
            ST_LEN: begin
                next_d  = (len_q != 8'd0) ? NX_PAYLOAD : NX_CRC;
                state_d = ST_WAIT;
            end
            ST_PAYLOAD: begin
                crc_d   = crc8_maxim_byte(crc_q, tx_data_q);
                rptr_d  = rptr_q + 8'd1;
                next_d  = (({1'b0, rptr_q} + 9'd1) < {1'b0, len_q}) ? NX_PAYLOAD : NX_CRC;
                state_d = ST_WAIT;
            end
            ST_CRC: begin
                next_d  = NX_DONE;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    case (next_q)
                        NX_LEN: begin
                            tx_data_d = len_q;
                            tx_wr_d   = 1'b1;
                            state_d   = ST_LEN;
                        end
                        NX_PAYLOAD: begin
                            tx_data_d = buf_rd_s;
                            tx_wr_d   = 1'b1;
                            state_d   = ST_PAYLOAD;
                        end
                        NX_CRC: begin
                            tx_data_d = crc_q;
                            tx_wr_d   = 1'b1;
                            state_d   = ST_CRC;
                        end
                        NX_DONE: begin
                            busy_d   = 1'b0;
                            wptr_d   = 8'd0;
                            frames_d = frames_q + 16'd1;
                            state_d  = ST_IDLE;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            next_q     <= NX_LEN;
            wptr_q     <= 8'd0;
            rptr_q     <= 8'd0;
            len_q      <= 8'd0;
            crc_q      <= 8'h00;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            dropped_q  <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_wr_q    <= 1'b0;
            frames_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            next_q     <= next_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            len_q      <= len_d;
            crc_q      <= crc_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
            tx_data_q  <= tx_data_d;
            tx_wr_q    <= tx_wr_d;
            frames_q   <= frames_d;
        end
    end

    assign busy        = busy_q;
    assign overflow    = overflow_q;
    assign tx_data     = tx_data_q;
    assign tx_wr       = tx_wr_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_s3g_resp_framer.sv
// Directed and randomized frames checked against a queue-based frame model.
module tb_s3g_resp_framer;
    import s3g_pkg::*;

    localparam int MAX = 32;

    logic        clk;
    logic        rst_n;
    logic [7:0]  pl_data;
    logic        pl_wr;
    logic        pl_commit;
    logic        busy;
    logic        overflow;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_done;
    logic [15:0] frames_sent;

    logic done_r;
    logic spur_r;
    assign tx_done = done_r | spur_r;

    int checks = 0;
    int errors = 0;
    int resp_delay = 4;

    logic [7:0] cap_q[$];   // bytes seen on tx_wr
    logic [7:0] exp_q[$];   // expected frame
    logic [7:0] mpay[$];    // model of buffered payload
    logic       mdrop;      // model: write dropped since last commit
    logic       m_ovf;      // model: overflow flag
    int         mframes;

    s3g_resp_framer #(.MAX_PAYLOAD(MAX), .START_BYTE(S3G_START_BYTE)) dut (
        .clk(clk), .rst_n(rst_n), .pl_data(pl_data), .pl_wr(pl_wr), .pl_commit(pl_commit),
        .busy(busy), .overflow(overflow), .tx_data(tx_data), .tx_wr(tx_wr),
        .tx_done(tx_done), .frames_sent(frames_sent)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Transceiver model: records each strobed byte, answers tx_done resp_delay cycles later.
    initial begin
        int  cnt;
        logic pending;
        done_r  = 1'b0;
        cnt     = 0;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            done_r = 1'b0;
            if (!rst_n) begin
                pending = 1'b0;
            end else if (tx_wr === 1'b1) begin
                cap_q.push_back(tx_data);
                pending = 1'b1;
                cnt = resp_delay;
            end else if (pending) begin
                if (cnt <= 1) begin
                    done_r  = 1'b1;
                    pending = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial CRC-8/Maxim over the whole payload, one message bit at a time.
    function automatic logic [7:0] crc_ref();
        int c = 0;
        foreach (mpay[i]) begin
            for (int b = 0; b < 8; b++) begin
                int mix;
                mix = (c ^ (int'(mpay[i]) >> b)) & 1;
                c = c >> 1;
                if (mix != 0) c = c ^ 'h8C;
            end
        end
        return 8'(c);
    endfunction

    task automatic wr_byte(input logic [7:0] b);
        pl_wr = 1'b1;
        pl_data = b;
        @(negedge clk);
        pl_wr = 1'b0;
        if (mpay.size() < MAX) begin
            mpay.push_back(b);
        end else begin
            mdrop = 1'b1;
            m_ovf = 1'b1;
        end
    endtask

    task automatic start_commit(input bit with_b, input logic [7:0] b, input string tag);
        cap_q.delete();
        if (with_b) begin
            if (mpay.size() < MAX) mpay.push_back(b);
            else mdrop = 1'b1;
        end
        exp_q.delete();
        exp_q.push_back(8'hD5);
        exp_q.push_back(8'(mpay.size()));
        foreach (mpay[i]) exp_q.push_back(mpay[i]);
        exp_q.push_back(crc_ref());
        m_ovf = mdrop;
        mdrop = 1'b0;
        mpay.delete();
        pl_commit = 1'b1;
        pl_wr = with_b;
        pl_data = b;
        @(negedge clk);
        pl_commit = 1'b0;
        pl_wr = 1'b0;
        chk({tag, "_first_txwr"}, 32'(tx_wr), 32'd1);
        chk({tag, "_first_byte"}, 32'(tx_data), 32'hD5);
        chk({tag, "_busy_set"}, 32'(busy), 32'd1);
        chk({tag, "_ovf_commit"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic finish_frame(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        chk({tag, "_nbytes"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
        end
        mframes++;
        chk({tag, "_frames"}, 32'(frames_sent), 32'(mframes));
        chk({tag, "_ovf_end"}, 32'(overflow), 32'(m_ovf));
    endtask

    initial begin
        logic [7:0] last_b;
        int         n;
        int         len;
        int         snap;
        bit         cb;
        rst_n = 1'b0; pl_data = 8'h00; pl_wr = 1'b0; pl_commit = 1'b0; spur_r = 1'b0;
        mdrop = 1'b0; m_ovf = 1'b0; mframes = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_txwr", 32'(tx_wr), 32'd0);
        chk("rst_txdata", 32'(tx_data), 32'd0);
        chk("rst_frames", 32'(frames_sent), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single OK byte, slow transceiver.
        resp_delay = 100;
        wr_byte(RC_OK);
        start_commit(1'b0, 8'h00, "ok1");
        finish_frame("ok1");
        last_b = (cap_q.size() == 4) ? cap_q[3] : 8'h00;
        chk("ok1_crc_d2", 32'(last_b), 32'hD2);

        // Three-byte response, then a lone unsupported code.
        resp_delay = 3;
        wr_byte(8'h81); wr_byte(8'hBA); wr_byte(8'hCE);
        start_commit(1'b0, 8'h00, "three");
        finish_frame("three");
        wr_byte(RC_UNSUPPORTED);
        start_commit(1'b0, 8'h00, "unsup");
        finish_frame("unsup");
        last_b = (cap_q.size() == 4) ? cap_q[3] : 8'h00;
        chk("unsup_crc_b3", 32'(last_b), 32'hB3);

        // Empty payload.
        resp_delay = 1;
        start_commit(1'b0, 8'h00, "empty");
        finish_frame("empty");

        // Overfill the buffer by one byte.
        resp_delay = 2;
        for (int i = 0; i < MAX; i++) wr_byte(8'(i));
        chk("full_no_ovf", 32'(overflow), 32'd0);
        wr_byte(8'(MAX));
        chk("full_ovf_set", 32'(overflow), 32'd1);
        start_commit(1'b0, 8'h00, "full");
        finish_frame("full");
        start_commit(1'b0, 8'h00, "after_full");
        finish_frame("after_full");

        // Writes, commit and a stray tx_done while busy.
        resp_delay = 6;
        wr_byte(8'h11); wr_byte(8'h22);
        start_commit(1'b0, 8'h00, "busy");
        spur_r = 1'b1;
        @(negedge clk);
        spur_r = 1'b0;
        pl_wr = 1'b1; pl_data = 8'h55;
        @(negedge clk);
        pl_wr = 1'b0;
        mdrop = 1'b1; m_ovf = 1'b1;
        chk("busy_wr_ovf", 32'(overflow), 32'd1);
        pl_commit = 1'b1;
        @(negedge clk);
        pl_commit = 1'b0;
        finish_frame("busy");
        wr_byte(8'h33);
        start_commit(1'b0, 8'h00, "post_busy");
        finish_frame("post_busy");

        // Random frames, sometimes with the last byte written in the commit cycle.
        for (int f = 0; f < 6; f++) begin
            resp_delay = $urandom_range(1, 6);
            len = $urandom_range(0, MAX);
            cb = (len > 0) && ($urandom_range(0, 1) == 1);
            for (int i = 0; i < len - int'(cb); i++) wr_byte(8'($urandom));
            start_commit(cb, 8'($urandom), $sformatf("rnd%0d", f));
            finish_frame($sformatf("rnd%0d", f));
        end

        // Asynchronous reset while the second payload byte is being strobed.
        resp_delay = 20;
        wr_byte(8'h81); wr_byte(8'hBA); wr_byte(8'hCE); wr_byte(8'h11);
        start_commit(1'b0, 8'h00, "abort");
        n = 0;
        while (!(tx_wr === 1'b1 && tx_data === 8'hBA) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached", 32'(tx_data), 32'hBA);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_txwr", 32'(tx_wr), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_txdata", 32'(tx_data), 32'd0);
        chk("abort_frames", 32'(frames_sent), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mpay.delete(); mdrop = 1'b0; m_ovf = 1'b0; mframes = 0;
        snap = cap_q.size();
        spur_r = 1'b1;
        @(negedge clk);
        spur_r = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_no_more_tx", cap_q.size(), snap);
        resp_delay = 5;
        wr_byte(RC_OK);
        start_commit(1'b0, 8'h00, "after_rst");
        finish_frame("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
